// File: rtl/clk_div_prog.sv
// clk_div_prog: runtime-programmable clock divider.
//   tick    : registered one-cycle enable pulse every D enabled cycles.
//   clk_out : registered 50%-duty square wave, period 2*D cycles.
// A new divisor is staged in a shadow register and only takes effect at a
// terminal count (or while the divider is stopped), so no runt periods occur.
// Optional build macro: CLK_DIV_SYNC_CLR_EN adds a synchronous phase clear
// input (sync_clr) for aligning several dividers.
module clk_div_prog #(
  parameter int W         = 16,
  parameter int RESET_DIV = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
`ifdef CLK_DIV_SYNC_CLR_EN
  input  logic         sync_clr,
`endif
  input  logic [W-1:0] div_val,
  input  logic         div_load,
  output logic         div_pending,
  output logic         load_err,
  output logic         tick,
  output logic         clk_out
);

  localparam logic [W-1:0] RST_D = W'(RESET_DIV);
  localparam logic [W-1:0] ONE   = W'(1);

  logic [W-1:0] cnt;
  logic [W-1:0] active_d;
  logic [W-1:0] shadow;
  logic         clr;
  logic         at_tc;
  logic         load_ok;
  logic         load_bad;
  logic         apply_now;

`ifdef CLK_DIV_SYNC_CLR_EN
  assign clr = sync_clr;
`else
  assign clr = 1'b0;
`endif

  // div_load is a one-cycle strobe with no back-pressure: every cycle it is
  // high, div_val is consumed (accepted if non-zero, rejected with load_err
  // if zero). The last accepted value before the apply point wins.
  assign load_ok  = div_load && (div_val != '0);
  assign load_bad = div_load && (div_val == '0);

  // Terminal count: last cycle of the current period with the active divisor.
  assign at_tc = en && !clr && (cnt == (active_d - ONE));

  // A staged divisor is committed at TC, on a clear, or while stopped.
  assign apply_now = div_pending && (at_tc || clr || !en);

  // Counter, outputs and divisor bookkeeping; async active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt         <= '0;
      active_d    <= RST_D;
      shadow      <= RST_D;
      tick        <= 1'b0;
      clk_out     <= 1'b0;
      div_pending <= 1'b0;
      load_err    <= 1'b0;
    end else begin
      load_err <= load_bad;

      // Phase: clear has priority, then counting, else freeze.
      if (clr) begin
        cnt     <= '0;
        tick    <= 1'b0;
        clk_out <= 1'b0;
      end else if (en) begin
        if (at_tc) begin
          cnt     <= '0;
          tick    <= 1'b1;
          clk_out <= ~clk_out;
        end else begin
          cnt  <= cnt + ONE;
          tick <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
        // Stopped with a staged divisor: restart the period under the new D.
        if (div_pending) cnt <= '0;
      end

      // Commit a previously staged divisor.
      if (apply_now) begin
        active_d    <= shadow;
        div_pending <= 1'b0;
      end

      // A load landing exactly on an apply point bypasses the shadow wait.
      if (load_ok) begin
        shadow <= div_val;
        if (at_tc || clr) begin
          active_d    <= div_val;
          div_pending <= 1'b0;
        end else begin
          div_pending <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// tb_clk_div_prog: directed bench for clk_div_prog with a per-cycle
// reference model feeding an expected queue, plus tick-interval checks.
module tb_clk_div_prog;

  localparam int W         = 16;
  localparam int RESET_DIV = 1;

  logic         clk = 1'b0;
  logic         reset;
  logic         en;
  logic [W-1:0] div_val;
  logic         div_load;
  logic         div_pending;
  logic         load_err;
  logic         tick;
  logic         clk_out;
`ifdef CLK_DIV_SYNC_CLR_EN
  logic         sync_clr = 1'b0;
`endif

  clk_div_prog #(.W(W), .RESET_DIV(RESET_DIV)) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
`ifdef CLK_DIV_SYNC_CLR_EN
    .sync_clr    (sync_clr),
`endif
    .div_val     (div_val),
    .div_load    (div_load),
    .div_pending (div_pending),
    .load_err    (load_err),
    .tick        (tick),
    .clk_out     (clk_out)
  );

  // Clock / watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Scoreboard state
  logic [3:0] exp_q[$];
  int n_chk = 0;
  int n_err = 0;
  int cyc = 0;
  int last_tick_cyc = -1;

  // Reference model state
  logic [W-1:0] m_cnt, m_d, m_sh;
  logic         m_pend, m_tick, m_clk, m_err;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = '0; m_d = W'(RESET_DIV); m_sh = W'(RESET_DIV);
    m_pend = 1'b0; m_tick = 1'b0; m_clk = 1'b0; m_err = 1'b0;
  endtask

  // One posedge of the behavioural model, using the currently driven inputs.
  task automatic model_step();
    logic         tc, ld_ok;
    logic [W-1:0] n_cnt, n_d, n_sh;
    logic         n_pend;
    if (!reset) begin
      model_reset();
    end else begin
      tc     = en && (int'(m_cnt) == int'(m_d) - 1);
      ld_ok  = div_load && (div_val != 0);
      m_err  = div_load && (div_val == 0);
      n_cnt  = m_cnt; n_d = m_d; n_sh = m_sh; n_pend = m_pend;
      if (en) begin
        if (tc) begin n_cnt = 0; m_tick = 1'b1; m_clk = ~m_clk; end
        else begin n_cnt = m_cnt + 1'b1; m_tick = 1'b0; end
        if (tc && m_pend) begin n_d = m_sh; n_pend = 1'b0; end
      end else begin
        m_tick = 1'b0;
        if (m_pend) begin n_d = m_sh; n_cnt = 0; n_pend = 1'b0; end
      end
      if (ld_ok) begin
        n_sh = div_val;
        if (tc) begin n_d = div_val; n_pend = 1'b0; end
        else n_pend = 1'b1;
      end
      m_cnt = n_cnt; m_d = n_d; m_sh = n_sh; m_pend = n_pend;
    end
  endtask

  // Driver: advance one clock, comparing DUT outputs with the model.
  task automatic cycle();
    logic [3:0] e, o;
    model_step();
    exp_q.push_back({m_pend, m_err, m_tick, m_clk});
    @(posedge clk); #1;
    cyc++;
    o = {div_pending, load_err, tick, clk_out};
    e = exp_q.pop_front();
    check("outputs_vs_model", 32'(o), 32'(e));
    if (tick) last_tick_cyc = cyc;
  endtask

  task automatic wait_tick(int maxc);
    bit got;
    got = 1'b0;
    for (int i = 0; i < maxc && !got; i++) begin
      cycle();
      if (tick) got = 1'b1;
    end
    check("tick_within_budget", 32'(got), 32'd1);
  endtask

  // Directed sequence
  initial begin
    int k, t, h;
    reset = 1'b0; en = 1'b0; div_load = 1'b0; div_val = '0;
    model_reset();

    // Reset held 3 cycles
    repeat (3) cycle();
    check("reset_state", 32'({div_pending, load_err, tick, clk_out}), 32'd0);

    // D=1: divide-by-2, tick stays high
    reset = 1'b1; en = 1'b1;
    repeat (6) cycle();
    check("d1_tick_high", 32'(tick), 32'd1);
    check("d1_tick_every_cycle", 32'(last_tick_cyc), 32'(cyc));
    check("d1_clk_out_after_6", 32'(clk_out), 32'd0);

    // Load 5 while stopped, apply while stopped, then run
    en = 1'b0; div_load = 1'b1; div_val = 16'd5;
    cycle();
    check("d5_pending_set", 32'(div_pending), 32'd1);
    div_load = 1'b0;
    cycle();
    check("d5_pending_clear", 32'(div_pending), 32'd0);
    en = 1'b1; k = cyc + 1;
    wait_tick(10);
    check("d5_first_tick", 32'(last_tick_cyc - k), 32'd4);
    t = last_tick_cyc;
    wait_tick(10);
    check("d5_period", 32'(last_tick_cyc - t), 32'd5);
    h = 0;
    repeat (20) begin cycle(); h += int'(clk_out); end
    check("d5_duty_high_of_20", 32'(h), 32'd10);

    // D=4 running, load 3 at cnt=1
    en = 1'b0; div_load = 1'b1; div_val = 16'd4;
    cycle();
    div_load = 1'b0;
    cycle();
    en = 1'b1;
    wait_tick(10);
    t = last_tick_cyc;
    cycle();
    div_load = 1'b1; div_val = 16'd3;
    cycle();
    div_load = 1'b0;
    check("d4to3_pending", 32'(div_pending), 32'd1);
    wait_tick(10);
    check("d4to3_old_period", 32'(last_tick_cyc - t), 32'd4);
    check("d4to3_pending_clear", 32'(div_pending), 32'd0);
    t = last_tick_cyc;
    wait_tick(10);
    check("d3_period", 32'(last_tick_cyc - t), 32'd3);

    // Zero divisor load rejected
    div_load = 1'b1; div_val = 16'd0;
    cycle();
    div_load = 1'b0;
    check("zero_load_err", 32'(load_err), 32'd1);
    cycle();
    check("zero_load_err_pulse", 32'(load_err), 32'd0);
    check("zero_load_no_pending", 32'(div_pending), 32'd0);
    wait_tick(10);
    t = last_tick_cyc;
    wait_tick(10);
    check("zero_load_period_kept", 32'(last_tick_cyc - t), 32'd3);

    // Back-to-back loads 9 then 6: last wins
    div_load = 1'b1; div_val = 16'd9;
    cycle();
    div_val = 16'd6;
    cycle();
    div_load = 1'b0;
    check("b2b_pending", 32'(div_pending), 32'd1);
    wait_tick(10);
    check("b2b_pending_clear", 32'(div_pending), 32'd0);
    t = last_tick_cyc;
    wait_tick(12);
    check("b2b_last_wins", 32'(last_tick_cyc - t), 32'd6);

    // en low 7 cycles mid-period at D=6
    t = last_tick_cyc;
    cycle(); cycle();
    en = 1'b0;
    repeat (7) cycle();
    en = 1'b1;
    wait_tick(20);
    check("en_stretch", 32'(last_tick_cyc - t), 32'd13);

    // Async reset between edges at cnt=3
    wait_tick(10);
    repeat (3) cycle();
    #2 reset = 1'b0;
    #1;
    check("async_reset_now", 32'({div_pending, load_err, tick, clk_out}), 32'd0);
    model_reset();
    cycle();
    reset = 1'b1; k = cyc + 1;
    wait_tick(5);
    check("post_reset_first_tick", 32'(last_tick_cyc - k), 32'(RESET_DIV - 1));
    repeat (3) cycle();

    check("queue_drained", 32'(exp_q.size()), 32'd0);

    // Final report
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/clk_div_prog.md
Name: clk_div_prog

Overview:
- Parametrised, runtime-programmable successor of the fixed divide-by-2 block.
- Produces two outputs from the system clock:
  - a one-cycle clock-enable pulse (tick) every D enabled cycles;
  - a 50%-duty divided square wave (clk_out) with period 2*D cycles.
- D is loaded at runtime through a shadow register and applied glitch-free at a terminal count.
- Feeds the board's slow-clock consumers: display scan, debounce, single-step CPU clock.

Parameters:
- W, 16, width of divisor and phase counter.
- RESET_DIV, 1, active divisor after reset. Must be 1..2^W-1. With 1, clk_out is exactly divide-by-2.

Ports:
- clk  in  1  system clock, all logic on posedge.
- reset  in  1  asynchronous reset, active-low (0 = reset asserted).
- en  in  1  count enable. Low freezes the counter and clk_out.
- div_val  in  W  new divisor D, sampled when div_load=1.
- div_load  in  1  one-cycle load strobe.
- div_pending  out  1  high while a loaded divisor waits in the shadow register.
- load_err  out  1  one-cycle pulse when a load with div_val=0 is rejected.
- tick  out  1  registered one-cycle enable pulse.
- clk_out  out  1  registered divided clock, period 2*active_D.

Behaviour:
- Reset (reset=0, asynchronous):
  - cnt=0, active_D=RESET_DIV, shadow=RESET_DIV.
  - tick=0, clk_out=0, div_pending=0, load_err=0.
- Reset release: first posedge with reset=1 counts normally. No extra latency.
- Terminal count (TC) is the condition en=1 and cnt==active_D-1.
- Counting (en=1):
  - Not at TC: cnt<=cnt+1, tick<=0.
  - At TC: cnt<=0, tick<=1, clk_out<=~clk_out.
- Timing:
  - First tick is registered high D cycles after en first samples 1.
  - Then tick repeats every D cycles.
  - clk_out toggles in the same cycle that tick goes high.
- D=1: TC every enabled cycle, tick stays high continuously, clk_out toggles every cycle.
- en=0:
  - cnt and clk_out hold, tick<=0.
  - A pending shadow value is applied on the next cycle: active_D<=shadow, cnt<=0, div_pending<=0.
- Load, div_load=1 and div_val!=0:
  - shadow<=div_val, div_pending<=1.
  - Back-to-back loads: the last one wins.
- Load, div_load=1 and div_val==0:
  - Load is ignored; shadow and div_pending are unchanged.
  - load_err<=1 for exactly one cycle.
- Apply: at TC with div_pending=1, active_D<=shadow and div_pending<=0. The current period always completes with the old D, so there are no runt periods.
- Load and TC in the same cycle (valid div_val): div_val is applied directly at that TC (active_D<=div_val) and div_pending stays 0.
- Counter width: cnt is W bits and never exceeds active_D-1. D=2^W-1 is the maximum and must not overflow.
- Reset asserted mid-period: all state returns to reset values immediately, independent of clk.

Optional Feature:
- Macro: CLK_DIV_SYNC_CLR_EN.
- Defined: adds input sync_clr (1 bit). When sync_clr=1 at a posedge:
  - cnt<=0, tick<=0, clk_out<=0;
  - any pending shadow value is applied (div_pending<=0);
  - sync_clr has priority over counting and over TC.
  - This lets multiple dividers be phase-aligned.
- Undefined: no sync_clr port. Phase is set only by reset and en.

Test Plan:
- Reset held 3 cycles, then en=1, RESET_DIV=1 -> clk_out toggles every cycle (period 2 cycles, matching divide-by-2) and tick stays high continuously.
- Load div_val=5 while en=0, then en=1 -> div_pending goes 1 then 0. First tick 5 cycles after en=1, then every 5 cycles. clk_out period is 10 cycles with 50% duty.
- D=4 running, load div_val=3 at cnt=1 -> next tick still 4 cycles after the previous one, then every 3 cycles. div_pending clears on the switching tick.
- div_load with div_val=0 -> load_err high for 1 cycle; period and div_pending unchanged.
- Toggle en low for 7 cycles mid-period (D=6) -> tick is 0 and clk_out holds throughout. Counting resumes from the frozen cnt, and the period is stretched by exactly 7 cycles.
- Assert reset asynchronously between edges at D=6, cnt=3 -> outputs go to 0 immediately. After release, D=RESET_DIV and the first tick arrives RESET_DIV cycles later.
